// File: rtl/gf2_pkg.sv
// Shared helpers for the GF(2) multiply-accumulate engine.
// GF2_REDUCE_EN selects the reduced (W-bit) result width.
package gf2_pkg;

  localparam int MAX_W  = 32;
  localparam int MAX_PW = 2 * MAX_W - 1;

`ifdef GF2_REDUCE_EN
  localparam bit REDUCE_EN = 1'b1;
`else
  localparam bit REDUCE_EN = 1'b0;
`endif

  function automatic int gf2_rw(input int w);
    return REDUCE_EN ? w : 2 * w - 1;
  endfunction

  // Control half of the S1 stage; the products sit beside it per channel.
  typedef struct packed {
    logic valid;
    logic last;
    logic nz;
  } s1_ctl_t;

  // Operands are zero-extended by the caller, so the low 2W-1 bits hold the product.
  function automatic logic [MAX_PW-1:0] clmul(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
    logic [MAX_PW-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_W; i++) begin
      for (int j = 0; j < MAX_W; j++) begin
        p[i+j] = p[i+j] ^ (a[i] & b[j]);
      end
    end
    return p;
  endfunction

  // Clears each bit at or above x^w by folding in x^(k-w) * poly, top-down.
  function automatic logic [MAX_W-1:0] gf2_reduce(input logic [MAX_PW-1:0] x,
                                                  input int w,
                                                  input logic [MAX_W-1:0] poly);
    logic [MAX_PW-1:0] r;
    r = x;
    for (int k = MAX_PW - 1; k >= 1; k--) begin
      if (k >= w && r[k]) begin
        r[k] = 1'b0;
        r = r ^ (MAX_PW'(poly) << (k - w));
      end
    end
    return r[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/gf2_clmul.sv
// Combinational W x W carry-less multiplier producing a 2W-1 bit product.
module gf2_clmul
  import gf2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);

  assign p = (2*W-1)'(clmul(MAX_W'(a), MAX_W'(b)));

endmodule

// File: rtl/gf2_mac_pipe.sv
// Pipelined multi-channel GF(2) multiply-accumulate with per-frame results.
// Define GF2_REDUCE_EN to reduce the result modulo x^W+POLY before output.
module gf2_mac_pipe
  import gf2_pkg::*;
#(
  parameter int             W     = 8,
  parameter int             NCH   = 2,
  parameter int             CNT_W = 8,
  parameter logic [W-1:0]   POLY  = W'('h1B),
  localparam int            RW    = gf2_rw(W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   in_a,
  input  logic [NCH*W-1:0]   in_b,
  input  logic [NCH-1:0]     in_chmask,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RW-1:0]      out_data,
  output logic [CNT_W-1:0]   out_beats,
  output logic               out_sat
);

  localparam int               PW      = 2 * W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             adv;
  logic             accept;
  s1_ctl_t          s1_ctl_reg;
  logic [PW-1:0]    s1_prod_reg [NCH];
  logic [PW-1:0]    beat;
  logic [PW-1:0]    acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;
  logic [PW-1:0]    acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;
  logic [RW-1:0]    result;

  // Every stage moves together; a stalled result freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PW-1:0] prod;

      gf2_clmul #(.W(W)) u_clmul (
        .a (in_a[gi*W +: W]),
        .b (in_b[gi*W +: W]),
        .p (prod)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_prod_reg[gi] <= '0;
        end else if (adv && accept) begin
          s1_prod_reg[gi] <= in_chmask[gi] ? prod : '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_ctl_reg <= '0;
    end else if (adv) begin
      s1_ctl_reg.valid <= accept;
      if (accept) begin
        s1_ctl_reg.last <= in_last;
        s1_ctl_reg.nz   <= |in_chmask;
      end
    end
  end

  always_comb begin
    beat = '0;
    for (int c = 0; c < NCH; c++) begin
      beat = beat ^ s1_prod_reg[c];
    end
    if (!s1_ctl_reg.nz) begin
      beat = '0;
    end
  end

  // The counter pins at its maximum; sat marks that beats were dropped from the count.
  assign acc_next = acc_reg ^ beat;
  assign cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
  assign sat_next = sat_reg | (cnt_reg == CNT_MAX);

`ifdef GF2_REDUCE_EN
  assign result = RW'(gf2_reduce(MAX_PW'(acc_next), W, MAX_W'(POLY)));
`else
  assign result = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      sat_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_ctl_reg.valid && s1_ctl_reg.last;
      if (s1_ctl_reg.valid) begin
        if (s1_ctl_reg.last) begin
          out_data  <= result;
          out_beats <= cnt_next;
          out_sat   <= sat_next;
          acc_reg   <= '0;
          cnt_reg   <= '0;
          sat_reg   <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_next;
          sat_reg <= sat_next;
        end
      end
    end
  end

endmodule

// File: doc/gf2_mac_pipe.md
Name: gf2_mac_pipe

Overview:
Parametrised, pipelined GF(2) multiply-accumulate engine, generalising the fixed 8-bit two-pair XOR-of-AND slice.
- Each accepted beat carries NCH operand pairs (a[c], b[c]).
- Each pair yields a carry-less product. Products of enabled channels are XOR-combined and XOR-accumulated over a frame ending at in_last.
- Sits between operand staging and the syndrome/CRC/GHASH-style consumers; valid/ready on both sides.

Parameters:
W, 8, operand width per channel (2..32)
NCH, 2, number of operand channels (1..8)
CNT_W, 8, width of the frame beat counter
POLY, 8'h1B, reduction polynomial low W bits with x^W implicit; only used with GF2_REDUCE_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat this cycle
in_a  in  NCH*W  channel c at bits [c*W +: W]
in_b  in  NCH*W  channel c at bits [c*W +: W]
in_chmask  in  NCH  1 = channel contributes this beat
in_last  in  1  final beat of frame
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts result
out_data  out  RW  accumulated result; RW = 2W-1, or W with GF2_REDUCE_EN
out_beats  out  CNT_W  beats accepted in this frame
out_sat  out  1  beat count saturated at 2^CNT_W-1

Behaviour:
- Clocking and reset: single clock. rst_n sampled on clk only.
  - Reset values: out_valid=0, out_data=0, out_beats=0, out_sat=0, all stage valids=0, accumulator=0, counter=0.
  - in_ready reads 0 during reset.
- Product rule: clmul(a,b) bit k = XOR over i+j=k of a[i]&b[j], width 2W-1. Masked-off channels contribute 0. Beat value = XOR of the channel products.
- Pipeline:
  - S1 registers the per-channel products, in_last and the mask popcount-nonzero flag.
  - S2 holds the accumulator and beat counter.
  - OUT holds the result register.
- Advance: adv = !out_valid || out_ready; in_ready = adv. When adv=0 all stages hold, with no bubbles and no loss.
- Accept: a beat is accepted when in_valid && in_ready.
- Accumulate: on S1->S2 transfer:
  - acc <= acc ^ beat; cnt <= cnt+1, saturating at max and setting a sticky sat flag.
  - If S1.last: OUT loads acc^beat, cnt+1 (saturated) and sat; out_valid is set; acc, cnt and sat clear in the same cycle.
- Latency: result valid 2 cycles after the accepting edge of the in_last beat, with no backpressure.
- Throughput: one beat per cycle sustained. Back-to-back frames need no idle cycle.
- Single-beat frame (in_last on first beat): out_beats=1.
- All-channels-masked beat: counts as a beat and contributes 0.
- Output hold: out_data, out_beats and out_sat are stable while out_valid && !out_ready. out_valid drops the cycle after the handshake unless a new result loads in that same cycle.
- Reset mid-frame: the partial accumulation and any pending result are discarded, with no output.
- in_a, in_b, in_chmask and in_last are ignored when not accepted.

Optional Feature:
GF2_REDUCE_EN
- Defined:
  - Adds a combinational reduction of the 2W-1 accumulator modulo x^W+POLY between S2 and OUT. No extra cycle.
  - RW=W.
  - Reduction is linear, so accumulating then reducing equals reducing per beat.
- Undefined: no reduction logic is built; RW=2W-1; POLY is unused.

Decomposition:
- Package gf2_pkg:
  - function clmul (W-generic via localparams)
  - function gf2_reduce
  - localparam helper for RW
  - typedef for the S1 stage struct (products, last, valid)
- Sub-module gf2_clmul: a combinational W x W carry-less multiplier, instantiated NCH times in S1.
- Counter, accumulator and handshake stay in the top module.

Test Plan:
- Single beat, W=8, NCH=2, mask=2'b01, a0=0x03, b0=0x03, last=1 -> out_data=0x0005, out_beats=1, out_valid 2 cycles later.
- Channel cancel: a0=0xFF, b0=0x01, a1=0xFF, b1=0x01, mask=2'b11, last=1 -> out_data=0x0000.
- Three-beat frame with products 0x01, 0x02, 0x04 then last -> out_data=0x0007, out_beats=3. The next frame starts the following cycle and its result is 0x0001 for a single beat a0=b0=0x01.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid high -> in_ready=0 and outputs stable. After release, all results arrive in order and none are lost.
- CNT_W=2, 5-beat frame -> out_beats=3, out_sat=1.
- GF2_REDUCE_EN, POLY=0x1B, a0=0x57, b0=0x83 -> 0xC1 (unreduced 0x2B79 without macro).
- Assert rst_n=0 for 1 cycle mid-frame after 2 beats -> no output; a new single-beat frame yields only its own product.
